uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Shares the single UART transmit path (FIFO write port: f_write / i_TxData) between N_REQ byte-stream requesters, e.g. CPU core, debug monitor and status reporter. Arbitration is round-robin at packet granularity: a granted requester keeps the port until it marks a byte as last, or until MAX_BURST bytes have been written. Sits between the requesters and UART_TOP; it drives UART_TOP's f_write/i_TxData and observes the TX FIFO full flag.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width
MAX_BURST, 16, max bytes per grant before forced release (1..255)
TIMEOUT, 64, idle cycles mid-packet before forced release (only with UART_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  N_REQ  requester i has a byte on req_data slice i
req_last  in  N_REQ  byte on slice i is the last of its packet
req_data  in  N_REQ*DATA_W  packed bytes, slice i = [i*DATA_W +: DATA_W]
req_ready  out  N_REQ  byte from requester i accepted this cycle
fifo_full  in  1  TX FIFO full flag
f_write  out  1  FIFO write strobe (to UART_TOP f_write)
o_TxData  out  DATA_W  FIFO write data (to UART_TOP i_TxData)
o_grant  out  N_REQ  one-hot current owner, 0 when idle
o_busy  out  1  a grant is held
o_timeout  out  1  one-cycle pulse on timeout release (0 without the macro)

Behaviour:
- Reset: state IDLE, rr_ptr=0, burst_cnt=0, o_grant=0, o_busy=0, f_write=0, o_TxData=0, req_ready=0, o_timeout=0. Reset takes priority in every state; a packet in progress is abandoned with no further writes.
- FSM has three states: IDLE, ARB, BUSY.
- IDLE: if any req_valid is set, go to ARB on the next cycle; otherwise stay.
- ARB (one cycle): select the first requester with req_valid set, searching i = rr_ptr, rr_ptr+1, ... modulo N_REQ. Register the one-hot o_grant, clear burst_cnt, go to BUSY. If no req_valid is set (requester withdrew), return to IDLE.
- BUSY: let g be the granted index. Define accept = req_valid[g] & ~fifo_full.
  - f_write = accept, combinational from registered grant/state.
  - o_TxData = req_data slice g, combinational.
  - req_ready[g] = accept; all other req_ready bits are 0.
  - Each accept increments burst_cnt.
- Release occurs when accept & (req_last[g] | burst_cnt == MAX_BURST-1). On release: next state IDLE, o_grant cleared, rr_ptr = (g+1) mod N_REQ.
- Minimum arbitration overhead is 2 idle cycles (IDLE, ARB) between packets. Throughput within a packet is 1 byte/cycle.
- If fifo_full is high, no write occurs and the grant is held. The byte is retried each cycle, so no data is lost or duplicated.
- If req_valid[g] drops mid-packet, the grant is held; behaviour with the macro enabled is described under Optional Feature.
- Requests from non-granted requesters are ignored until the next ARB. Only one f_write can ever occur per cycle.
- o_busy = (state == BUSY).
- Requester contract: req_data, req_last and req_valid must be held stable while req_valid=1 and req_ready=0.

Optional Feature:
UART_ARB_TIMEOUT_EN
- Defined: an idle counter counts consecutive BUSY cycles with req_valid[g]=0; fifo_full stalls do not count. When it reaches TIMEOUT, the block releases the grant exactly as on a last byte (rr_ptr advances) and pulses o_timeout for one cycle. The counter clears on accept and on entering BUSY.
- Undefined: no counter; the grant is held indefinitely; o_timeout is tied to 0.

Test Plan:
- Single requester: req1 sends 3 bytes 0x41, 0x42, 0x43 (last on 0x43), fifo_full=0 -> f_write high for 3 consecutive cycles with that data, req_ready[1] on the same cycles, then IDLE; rr_ptr=2.
- Round-robin: all 4 requesters continuously valid with 1-byte packets, rr_ptr=0 -> grant order 0,1,2,3,0; each write separated by 2 idle cycles.
- Burst cap: MAX_BURST=16, req0 sends a 20-byte packet with no last in the first 16, req2 valid -> 16 writes from req0, then req2 is granted, then req0 resumes with its 17th byte.
- Backpressure: fifo_full asserted for 5 cycles mid-packet (after byte 0x10 of bytes 0x10, 0x11) -> no f_write during the stall; 0x11 is written exactly once after fifo_full falls.
- Reset mid-packet: reset asserted in BUSY after 2 of 4 bytes -> the next cycle shows f_write=0, o_grant=0, o_busy=0, rr_ptr=0.
- Timeout (macro defined, TIMEOUT=64): req3 drops valid after byte 1 of a 3-byte packet -> at idle count 64, o_timeout pulses for 1 cycle, grant is released, rr_ptr=0. Without the macro the grant is still held after 200 cycles.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART TX FIFO write port among N_REQ byte streams.
// Optional mid-packet idle timeout release is enabled with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_last,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     fifo_full,
  output logic                     f_write,
  output logic [DATA_W-1:0]        o_TxData,
  output logic [N_REQ-1:0]         o_grant,
  output logic                     o_busy,
  output logic                     o_timeout
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = 8;

  if (N_REQ < 2 || N_REQ > 8 || DATA_W < 1 || MAX_BURST < 1 || MAX_BURST > 255 || TIMEOUT < 1)
  begin : gBadParams
    $error("uart_tx_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    BUSY = 2'd2
  } arbState_e;

  arbState_e          state;
  arbState_e          nextState;
  logic [IDX_W-1:0]   rrPtr;
  logic [IDX_W-1:0]   grantIdx;
  logic [IDX_W-1:0]   selIdx;
  logic [IDX_W-1:0]   candIdx;
  logic               found;
  logic [CNT_W-1:0]   burstCnt;
  logic [DATA_W-1:0]  reqBytes [N_REQ];
  logic               accept;
  logic               pktDone;
  logic               timeoutHit;

  // Unpack the requester byte lanes.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      reqBytes[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // First valid requester at or after rrPtr, wrapping.
  always_comb begin
    found   = 1'b0;
    selIdx  = '0;
    candIdx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      candIdx = IDX_W'((32'(rrPtr) + 32'(k)) % N_REQ);
      if (!found && req_valid[candIdx]) begin
        found  = 1'b1;
        selIdx = candIdx;
      end
    end
  end

  // Reset blocks any write in the cycle it is asserted, so an abandoned packet emits nothing more.
  assign accept  = (state == BUSY) & req_valid[grantIdx] & ~fifo_full & ~reset;
  assign pktDone = accept & (req_last[grantIdx] | (burstCnt == CNT_W'(MAX_BURST - 1)));

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] idleCnt;
  logic            timeoutPulse;

  assign timeoutHit = (state == BUSY) & ~req_valid[grantIdx] & ~reset &
                      (idleCnt == TO_W'(TIMEOUT - 1));

  // Counts starved BUSY cycles; full-FIFO stalls with data present do not count.
  always_ff @(posedge clk) begin
    if (reset) begin
      idleCnt      <= '0;
      timeoutPulse <= 1'b0;
    end else begin
      timeoutPulse <= timeoutHit;
      if (state == ARB || accept) begin
        idleCnt <= '0;
      end else if (state == BUSY && !req_valid[grantIdx]) begin
        idleCnt <= idleCnt + TO_W'(1);
      end
    end
  end

  assign o_timeout = timeoutPulse;
`else
  assign timeoutHit = 1'b0;
  assign o_timeout  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (|req_valid) nextState = ARB;
      ARB:     nextState = found ? BUSY : IDLE;
      BUSY:    if (pktDone || timeoutHit) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output logic, combinational from registered state and grant.
  always_comb begin
    f_write   = 1'b0;
    req_ready = '0;
    o_TxData  = '0;
    o_busy    = 1'b0;
    if (state == BUSY) begin
      o_busy   = 1'b1;
      o_TxData = reqBytes[grantIdx];
      f_write  = accept;
      if (accept) req_ready = N_REQ'(1) << grantIdx;
    end
  end

  // Grant, burst counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      rrPtr    <= '0;
      grantIdx <= '0;
      o_grant  <= '0;
      burstCnt <= '0;
    end else begin
      if (state == ARB && found) begin
        o_grant  <= N_REQ'(1) << selIdx;
        grantIdx <= selIdx;
        burstCnt <= '0;
      end
      if (accept) begin
        burstCnt <= burstCnt + CNT_W'(1);
      end
      if (pktDone || timeoutHit) begin
        o_grant <= '0;
        rrPtr   <= (grantIdx == IDX_W'(N_REQ - 1)) ? '0 : grantIdx + IDX_W'(1);
      end
    end
  end

endmodule
